axi_from_lite_upsizer: RTL
==========================

// Module: axi_from_lite_upsizer
// PURPOSE
//  Bridges a narrow AXI-Lite master onto a wider AXI slave, with an independent outstanding-transaction limit per direction.
//  Write data is steered onto byte lanes using the AW address. Read data is extracted from the lane recorded at AR time.
//  Sits between AXI-Lite peripherals/masters and the AXI fabric. Supersedes the fixed-width lite-to-full bridge.
// PARAMETERS
//  ADDR_WIDTH       48  address width, both ports
//  LITE_DATA_WIDTH  32  AXI-Lite data width, power of 2, >=8
//  DATA_WIDTH       64  AXI data width, power of 2, >= LITE_DATA_WIDTH
//  ID_VALUE         0   constant driven on aw_id/ar_id
//  MAX_OUTSTANDING  4   max in-flight writes and max in-flight reads, each counted separately (>=1)
// PORTS
//  clk     in   1     clock; one clock domain
//  rstn    in   1     reset, asynchronous assert, active-low
//  master  intf -     axi_lite_channel.slave; LITE_DATA_WIDTH data
//  slave   intf -     axi_channel.master; DATA_WIDTH data
// BEHAVIOUR
//  Static check: interface widths must equal the parameters, else $fatal.
//  Derived: R=DATA_WIDTH/LITE_DATA_WIDTH, LB=clog2(LITE_DATA_WIDTH/8), WB=clog2(DATA_WIDTH/8).
//  Derived: lane = addr[WB-1:LB]. lane is 0-width when R==1.
//  Fixed AXI fields: len=0, size=LB, burst=INCR, lock/cache/qos/region/user=0, id=ID_VALUE, w_last=1.
//  Address and prot: copied from master.
//  AW path, 1-entry register stage:
//   - master.aw_ready = !aw_reg_valid && !wlane_full && wcnt<MAX_OUTSTANDING.
//   - On master AW handshake: load aw_reg, set aw_reg_valid, push lane into wlane FIFO, wcnt++.
//   - slave.aw_* driven from aw_reg. slave.aw_valid=aw_reg_valid.
//   - aw_reg_valid clears on slave AW handshake.
//   - AW latency = 1 cycle.
//  W path, combinational:
//   - slave.w_valid = master.w_valid && !wlane_empty. master.w_ready = slave.w_ready && !wlane_empty.
//   - w_data = master.w_data replicated R times.
//   - w_strb = master.w_strb << (lane_head*LITE_DATA_WIDTH/8); zeros on all other lanes.
//   - Pop wlane on W handshake.
//   - W never waits on slave AWREADY: the FIFO is filled at master-side acceptance, which keeps AXI valid/ready independence.
//  B path: b_resp/b_valid/b_ready pass through. wcnt-- on B handshake. b_id/b_user discarded.
//  AR path, combinational:
//   - slave.ar_valid = master.ar_valid && rcnt<MAX_OUTSTANDING.
//   - master.ar_ready = slave.ar_ready && rcnt<MAX_OUTSTANDING.
//   - On AR handshake: push lane into rlane FIFO (depth MAX_OUTSTANDING), rcnt++.
//  R path: master.r_data = slave.r_data[rlane_head*LITE_DATA_WIDTH +: LITE_DATA_WIDTH].
//   - r_resp/r_valid/r_ready pass through.
//   - Pop rlane and rcnt-- on R handshake. r_id/r_last/r_user discarded.
//  FIFO boundaries:
//   - FIFOs are depth MAX_OUTSTANDING with wrapping pointers.
//   - Push and pop in the same cycle: count unchanged. Both allowed when non-empty.
//   - Full blocks acceptance even when a pop occurs in the same cycle.
//   - Simultaneous inc/dec on wcnt or rcnt: count unchanged.
//  Protocol assertions: no B when wcnt==0; no R when rcnt==0; r_last must be 1.
//  Reset, any time including mid-transaction:
//   - aw_reg_valid=0, both FIFOs empty, wcnt=rcnt=0.
//   - Hence slave.aw_valid=0 and slave.w_valid=0; master.aw_ready=1 on rstn release.
//   - In-flight transactions are abandoned; the surrounding fabric is reset with the bridge.
//  R==1: lane logic degenerates. Behaviour equals a plain bridge plus the AW register stage.
// TESTING (LITE=32, DATA=64, MAX_OUTSTANDING=2 unless noted)
//  1. Write 0x1004 data 0xDEADBEEF strb 0xF:
//     -> slave aw_addr 0x1004, aw_size 2, w_data 0xDEADBEEF_DEADBEEF, w_strb 0xF0, w_last 1.
//     -> B OKAY returned to master.
//  2. W valid 3 cycles before AW:
//     -> slave.w_valid 0 until the cycle after master AW handshake.
//     -> slave.aw_valid and slave.w_valid both rise together that cycle.
//  3. Reads 0x2000 then 0x2004; slave returns 0x11111111_22222222 then 0x33333333_44444444:
//     -> master gets 0x22222222 then 0x33333333.
//  4. Three ARs with R withheld:
//     -> third AR: master.ar_ready=0, slave.ar_valid=0.
//     -> third AR issues the cycle after the first R handshake.
//  5. Two writes outstanding plus aw_reg occupied, then rstn low 1 cycle:
//     -> slave.aw_valid=0, slave.w_valid=0, counters 0, master.aw_ready=1 after release.
//  6. slave b_resp=SLVERR, r_resp=DECERR: passed unchanged to master. Counters return to 0.

Source files
------------

// File: rtl/axi_from_lite_upsizer.sv
// AXI-Lite to wide AXI bridge. Writes are steered onto the byte lane selected
// by the AW address; reads are extracted from the lane recorded at AR time.
// Writes and reads each have their own outstanding-transaction limit.

// Small lane-index FIFO with wrapping pointers; full blocks pushes even when a
// pop happens in the same cycle.
module axi_from_lite_upsizer_lane_fifo #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage write; contents are don't-care while the entry is unoccupied.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module axi_from_lite_upsizer #(
  parameter int unsigned ADDR_WIDTH      = 48,
  parameter int unsigned LITE_DATA_WIDTH = 32,
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned ID_WIDTH        = 4,
  parameter int unsigned USER_WIDTH      = 1,
  parameter int unsigned ID_VALUE        = 0,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  // AXI-Lite side (this bridge is the slave)
  input  logic [ADDR_WIDTH-1:0]        master_aw_addr,
  input  logic [2:0]                   master_aw_prot,
  input  logic                         master_aw_valid,
  output logic                         master_aw_ready,
  input  logic [LITE_DATA_WIDTH-1:0]   master_w_data,
  input  logic [LITE_DATA_WIDTH/8-1:0] master_w_strb,
  input  logic                         master_w_valid,
  output logic                         master_w_ready,
  output logic [1:0]                   master_b_resp,
  output logic                         master_b_valid,
  input  logic                         master_b_ready,
  input  logic [ADDR_WIDTH-1:0]        master_ar_addr,
  input  logic [2:0]                   master_ar_prot,
  input  logic                         master_ar_valid,
  output logic                         master_ar_ready,
  output logic [LITE_DATA_WIDTH-1:0]   master_r_data,
  output logic [1:0]                   master_r_resp,
  output logic                         master_r_valid,
  input  logic                         master_r_ready,
  // Wide AXI side (this bridge is the master)
  output logic [ID_WIDTH-1:0]          slave_aw_id,
  output logic [ADDR_WIDTH-1:0]        slave_aw_addr,
  output logic [7:0]                   slave_aw_len,
  output logic [2:0]                   slave_aw_size,
  output logic [1:0]                   slave_aw_burst,
  output logic                         slave_aw_lock,
  output logic [3:0]                   slave_aw_cache,
  output logic [2:0]                   slave_aw_prot,
  output logic [3:0]                   slave_aw_qos,
  output logic [3:0]                   slave_aw_region,
  output logic [USER_WIDTH-1:0]        slave_aw_user,
  output logic                         slave_aw_valid,
  input  logic                         slave_aw_ready,
  output logic [DATA_WIDTH-1:0]        slave_w_data,
  output logic [DATA_WIDTH/8-1:0]      slave_w_strb,
  output logic                         slave_w_last,
  output logic [USER_WIDTH-1:0]        slave_w_user,
  output logic                         slave_w_valid,
  input  logic                         slave_w_ready,
  input  logic [ID_WIDTH-1:0]          slave_b_id,
  input  logic [1:0]                   slave_b_resp,
  input  logic [USER_WIDTH-1:0]        slave_b_user,
  input  logic                         slave_b_valid,
  output logic                         slave_b_ready,
  output logic [ID_WIDTH-1:0]          slave_ar_id,
  output logic [ADDR_WIDTH-1:0]        slave_ar_addr,
  output logic [7:0]                   slave_ar_len,
  output logic [2:0]                   slave_ar_size,
  output logic [1:0]                   slave_ar_burst,
  output logic                         slave_ar_lock,
  output logic [3:0]                   slave_ar_cache,
  output logic [2:0]                   slave_ar_prot,
  output logic [3:0]                   slave_ar_qos,
  output logic [3:0]                   slave_ar_region,
  output logic [USER_WIDTH-1:0]        slave_ar_user,
  output logic                         slave_ar_valid,
  input  logic                         slave_ar_ready,
  input  logic [ID_WIDTH-1:0]          slave_r_id,
  input  logic [DATA_WIDTH-1:0]        slave_r_data,
  input  logic [1:0]                   slave_r_resp,
  input  logic                         slave_r_last,
  input  logic [USER_WIDTH-1:0]        slave_r_user,
  input  logic                         slave_r_valid,
  output logic                         slave_r_ready
);
  localparam int unsigned R      = DATA_WIDTH / LITE_DATA_WIDTH;
  localparam int unsigned LSW    = LITE_DATA_WIDTH / 8;
  localparam int unsigned DSW    = DATA_WIDTH / 8;
  localparam int unsigned LB     = $clog2(LSW);
  localparam int unsigned WB     = $clog2(DSW);
  localparam int unsigned LANE_W = (WB > LB) ? (WB - LB) : 1;
  localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1);

  if (LITE_DATA_WIDTH < 8 || DATA_WIDTH < LITE_DATA_WIDTH ||
      (1 << $clog2(LITE_DATA_WIDTH)) != LITE_DATA_WIDTH ||
      (1 << $clog2(DATA_WIDTH)) != DATA_WIDTH ||
      MAX_OUTSTANDING < 1) begin : g_bad_params
    $fatal(1, "axi_from_lite_upsizer: illegal parameter combination");
  end

  logic                  aw_reg_valid;
  logic [ADDR_WIDTH-1:0] aw_reg_addr;
  logic [2:0]            aw_reg_prot;
  logic [CNT_W-1:0]      wcnt;
  logic [CNT_W-1:0]      rcnt;
  logic [LANE_W-1:0]     aw_lane;
  logic [LANE_W-1:0]     ar_lane;
  logic [LANE_W-1:0]     wlane_head;
  logic [LANE_W-1:0]     rlane_head;
  logic                  wlane_full;
  logic                  wlane_empty;
  logic                  rlane_full;
  logic                  rlane_empty;
  logic                  w_can_issue;
  logic                  r_can_issue;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  b_hs;
  logic                  ar_hs;
  logic                  r_hs;

  // Lane index collapses to a constant zero when both ports are the same width.
  if (R > 1) begin : g_lane
    assign aw_lane = master_aw_addr[WB-1:LB];
    assign ar_lane = master_ar_addr[WB-1:LB];
  end else begin : g_no_lane
    assign aw_lane = '0;
    assign ar_lane = '0;
  end

  assign w_can_issue = (wcnt < CNT_W'(MAX_OUTSTANDING));
  assign r_can_issue = (rcnt < CNT_W'(MAX_OUTSTANDING));

  assign master_aw_ready = !aw_reg_valid && !wlane_full && w_can_issue;
  assign aw_hs = master_aw_valid && master_aw_ready;
  assign w_hs  = slave_w_valid && slave_w_ready;
  assign b_hs  = slave_b_valid && master_b_ready;
  assign ar_hs = slave_ar_valid && slave_ar_ready;
  assign r_hs  = slave_r_valid && master_r_ready;

  // AW register stage: one entry, loaded on master acceptance, freed on slave acceptance.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      aw_reg_valid <= 1'b0;
      aw_reg_addr  <= '0;
      aw_reg_prot  <= '0;
    end else if (aw_hs) begin
      aw_reg_valid <= 1'b1;
      aw_reg_addr  <= master_aw_addr;
      aw_reg_prot  <= master_aw_prot;
    end else if (slave_aw_valid && slave_aw_ready) begin
      aw_reg_valid <= 1'b0;
    end
  end

  // Outstanding write/read counters; simultaneous inc and dec cancel.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wcnt <= '0;
      rcnt <= '0;
    end else begin
      case ({aw_hs, b_hs})
        2'b10:   wcnt <= wcnt + 1'b1;
        2'b01:   wcnt <= wcnt - 1'b1;
        default: wcnt <= wcnt;
      endcase
      case ({ar_hs, r_hs})
        2'b10:   rcnt <= rcnt + 1'b1;
        2'b01:   rcnt <= rcnt - 1'b1;
        default: rcnt <= rcnt;
      endcase
    end
  end

  // Write lanes are queued at master-side AW acceptance, so W never depends on slave AWREADY.
  axi_from_lite_upsizer_lane_fifo #(.WIDTH(LANE_W), .DEPTH(MAX_OUTSTANDING)) u_wlane (
    .clk(clk), .rstn(rstn),
    .push(aw_hs), .push_data(aw_lane),
    .pop(w_hs), .pop_data(wlane_head),
    .full(wlane_full), .empty(wlane_empty)
  );

  axi_from_lite_upsizer_lane_fifo #(.WIDTH(LANE_W), .DEPTH(MAX_OUTSTANDING)) u_rlane (
    .clk(clk), .rstn(rstn),
    .push(ar_hs), .push_data(ar_lane),
    .pop(r_hs), .pop_data(rlane_head),
    .full(rlane_full), .empty(rlane_empty)
  );

  assign slave_aw_id     = ID_WIDTH'(ID_VALUE);
  assign slave_aw_addr   = aw_reg_addr;
  assign slave_aw_len    = '0;
  assign slave_aw_size   = 3'(LB);
  assign slave_aw_burst  = 2'b01;
  assign slave_aw_lock   = 1'b0;
  assign slave_aw_cache  = '0;
  assign slave_aw_prot   = aw_reg_prot;
  assign slave_aw_qos    = '0;
  assign slave_aw_region = '0;
  assign slave_aw_user   = '0;
  assign slave_aw_valid  = aw_reg_valid;

  assign slave_w_valid  = master_w_valid && !wlane_empty;
  assign master_w_ready = slave_w_ready && !wlane_empty;
  assign slave_w_data   = {R{master_w_data}};
  assign slave_w_strb   = DSW'(master_w_strb) << (wlane_head * LSW);
  assign slave_w_last   = 1'b1;
  assign slave_w_user   = '0;

  assign master_b_resp  = slave_b_resp;
  assign master_b_valid = slave_b_valid;
  assign slave_b_ready  = master_b_ready;

  assign slave_ar_id     = ID_WIDTH'(ID_VALUE);
  assign slave_ar_addr   = master_ar_addr;
  assign slave_ar_len    = '0;
  assign slave_ar_size   = 3'(LB);
  assign slave_ar_burst  = 2'b01;
  assign slave_ar_lock   = 1'b0;
  assign slave_ar_cache  = '0;
  assign slave_ar_prot   = master_ar_prot;
  assign slave_ar_qos    = '0;
  assign slave_ar_region = '0;
  assign slave_ar_user   = '0;
  assign slave_ar_valid  = master_ar_valid && r_can_issue;
  assign master_ar_ready = slave_ar_ready && r_can_issue;

  assign master_r_data  = slave_r_data[rlane_head * LITE_DATA_WIDTH +: LITE_DATA_WIDTH];
  assign master_r_resp  = slave_r_resp;
  assign master_r_valid = slave_r_valid;
  assign slave_r_ready  = master_r_ready;

  logic unused_ok;
  assign unused_ok = ^{slave_b_id, slave_b_user, slave_r_id, slave_r_user, slave_r_last,
                       rlane_full, rlane_empty};

  b_without_write: assert property (@(posedge clk) disable iff (!rstn)
    slave_b_valid |-> (wcnt != '0));
  r_without_read: assert property (@(posedge clk) disable iff (!rstn)
    slave_r_valid |-> (rcnt != '0));
  r_not_last: assert property (@(posedge clk) disable iff (!rstn)
    slave_r_valid |-> slave_r_last);
endmodule
